// File: rtl/display_mode_controller.sv
// Display source sequencer for the alarm clock: picks time/alarm/keypad source,
// runs the keypad digit-entry handshake and blanks the display while ringing.
module display_mode_controller #(
   parameter int ALARM_SHOW_SECS  = 5,
   parameter int KEY_TIMEOUT_SECS = 10,
   parameter int DIGITS           = 4,
   parameter int TIMER_WIDTH      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       one_second,
   input  logic       show_alarm_btn,
   input  logic       key_valid,
   input  logic       load_alarm_btn,
   input  logic       load_time_btn,
   input  logic       alarm_ringing,
   output logic [1:0] selector,
   output logic       shift_key,
   output logic       load_new_alarm,
   output logic       load_new_time,
   output logic [2:0] digit_count,
   output logic       display_blank,
   output logic [1:0] state_dbg
);

   // Handshake: every input is a single-cycle pulse (alarm_ringing a level) sampled
   // on posedge clk; there is no back-pressure, and every output is a registered
   // one-cycle pulse/level appearing in the cycle after the causing input.
   typedef enum logic [1:0] {
      SHOW_TIME  = 2'd0,
      SHOW_ALARM = 2'd1,
      KEY_ENTRY  = 2'd2
   } state_t;

   localparam logic [TIMER_WIDTH-1:0] ALARM_LAST = TIMER_WIDTH'(ALARM_SHOW_SECS - 1);
   localparam logic [TIMER_WIDTH-1:0] KEY_LAST   = TIMER_WIDTH'(KEY_TIMEOUT_SECS - 1);
   localparam logic [2:0]             DIGITS_C   = 3'(DIGITS);

   state_t                 state_q, state_d;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic [2:0]             digit_count_q, digit_count_d;
   logic [1:0]             selector_q, selector_d;
   logic                   shift_key_q, shift_key_d;
   logic                   load_new_alarm_q, load_new_alarm_d;
   logic                   load_new_time_q, load_new_time_d;
   logic                   display_blank_q, display_blank_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= SHOW_TIME;
         timer_q          <= '0;
         digit_count_q    <= 3'd0;
         selector_q       <= 2'd0;
         shift_key_q      <= 1'b0;
         load_new_alarm_q <= 1'b0;
         load_new_time_q  <= 1'b0;
         display_blank_q  <= 1'b0;
      end else begin
         state_q          <= state_d;
         timer_q          <= timer_d;
         digit_count_q    <= digit_count_d;
         selector_q       <= selector_d;
         shift_key_q      <= shift_key_d;
         load_new_alarm_q <= load_new_alarm_d;
         load_new_time_q  <= load_new_time_d;
         display_blank_q  <= display_blank_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      timer_d          = timer_q + {{(TIMER_WIDTH-1){1'b0}}, one_second};
      digit_count_d    = digit_count_q;
      shift_key_d      = 1'b0;
      load_new_alarm_d = 1'b0;
      load_new_time_d  = 1'b0;
      selector_d       = 2'd0;
      display_blank_d  = 1'b0;

      case (state_q)
         SHOW_TIME: begin
            if (key_valid) begin
               state_d       = KEY_ENTRY;
               timer_d       = '0;
               shift_key_d   = 1'b1;
               digit_count_d = 3'd1;
            end else if (show_alarm_btn) begin
               state_d = SHOW_ALARM;
               timer_d = '0;
            end
         end
         SHOW_ALARM: begin
            if (key_valid) begin
               state_d       = KEY_ENTRY;
               timer_d       = '0;
               shift_key_d   = 1'b1;
               digit_count_d = 3'd1;
            end else if (show_alarm_btn) begin
               timer_d = '0;
            end else if (one_second && timer_q == ALARM_LAST) begin
               state_d = SHOW_TIME;
               timer_d = '0;
            end
         end
         KEY_ENTRY: begin
            // A load only counts once the entry is complete; a partial entry keeps its timer.
            if ((load_time_btn || load_alarm_btn) && digit_count_q == DIGITS_C) begin
               timer_d       = '0;
               digit_count_d = 3'd0;
               if (load_time_btn) begin
                  state_d         = SHOW_TIME;
                  load_new_time_d = 1'b1;
               end else begin
                  state_d          = SHOW_ALARM;
                  load_new_alarm_d = 1'b1;
               end
            end else if (key_valid) begin
               timer_d = '0;
               if (digit_count_q < DIGITS_C) begin
                  shift_key_d   = 1'b1;
                  digit_count_d = digit_count_q + 3'd1;
               end
            end else if (one_second && timer_q == KEY_LAST) begin
               state_d       = SHOW_TIME;
               timer_d       = '0;
               digit_count_d = 3'd0;
            end
         end
         default: begin
            state_d       = SHOW_TIME;
            timer_d       = '0;
            digit_count_d = 3'd0;
         end
      endcase

      case (state_d)
         SHOW_ALARM: selector_d = 2'd1;
         KEY_ENTRY:  selector_d = 2'd2;
         default:    selector_d = 2'd0;
      endcase

      // Blank flips per tick only while staying in SHOW_TIME with the alarm ringing.
      if (state_q == SHOW_TIME && state_d == SHOW_TIME && alarm_ringing)
         display_blank_d = display_blank_q ^ one_second;
   end

   assign selector       = selector_q;
   assign shift_key      = shift_key_q;
   assign load_new_alarm = load_new_alarm_q;
   assign load_new_time  = load_new_time_q;
   assign digit_count    = digit_count_q;
   assign display_blank  = display_blank_q;
   assign state_dbg      = state_q;

endmodule
